bus_write_buffer: RTL



---
 rtl/bus_write_buffer_pkg.sv | 25 ++
 rtl/bus_write_buffer_if.sv | 36 +++
 rtl/bus_write_buffer_fifo.sv | 72 +++++++
 rtl/bus_write_buffer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bus_write_buffer_pkg.sv
// Shared types and widths for the posted-write buffer: FSM state encodings
// and the FIFO entry layout.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ACK,
        C_READ
    } cpu_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WRITE,
        B_READ
    } bus_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/bus_write_buffer_if.sv
// CPU-side and bus-side signals of the write buffer. The slave modport is the
// buffer itself; the master modport is the CPU/arbiter environment around it.
interface bus_write_buffer_if;
    import bus_pkg::*;

    logic              i_cpu_rw;
    logic              i_cpu_request;
    logic              o_cpu_ready;
    logic [ADDR_W-1:0] i_cpu_address;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic [DATA_W-1:0] o_cpu_rdata;
    logic              o_bus_rw;
    logic              o_bus_request;
    logic              i_bus_ready;
    logic [ADDR_W-1:0] o_bus_address;
    logic [DATA_W-1:0] i_bus_rdata;
    logic [DATA_W-1:0] o_bus_wdata;
    logic              o_pending;

    modport slave (
        input  i_cpu_rw, i_cpu_request, i_cpu_address, i_cpu_wdata,
        input  i_bus_ready, i_bus_rdata,
        output o_cpu_ready, o_cpu_rdata,
        output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
        output o_pending
    );

    modport master (
        output i_cpu_rw, i_cpu_request, i_cpu_address, i_cpu_wdata,
        output i_bus_ready, i_bus_rdata,
        input  o_cpu_ready, o_cpu_rdata,
        input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
        input  o_pending
    );

endinterface

// File: rtl/bus_write_buffer_fifo.sv
// Generic single-clock FIFO with synchronous reset. DEPTH must be a power of
// two so the pointers wrap naturally.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != FULL_COUNT);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head is read asynchronously so the drain FSM can load it in the cycle
    // the FIFO first becomes non-empty.
    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/bus_write_buffer.sv
// Posted-write buffer: CPU writes complete into a FIFO and drain to the bus in
// order; CPU reads wait for the FIFO to drain, preserving read-after-write order.
module bus_write_buffer
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    bus_write_buffer_if.slave  io
);

    cpu_state_t        cpu_state_q, cpu_state_d;
    bus_state_t        bus_state_q, bus_state_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              bus_rw_q, bus_rw_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    wb_entry_t               fifo_in, fifo_head;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    read_done;

    assign fifo_in.address = io.i_cpu_address;
    assign fifo_in.wdata   = io.i_cpu_wdata;

    sync_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clock),
        .srst      (i_reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign read_done = (bus_state_q == B_READ) && io.i_bus_ready;

    // CPU side. C_ACK never looks at the request, so a request still high
    // while the CPU observes o_cpu_ready cannot be taken twice.
    always_comb begin
        cpu_state_d = cpu_state_q;
        fifo_push   = 1'b0;
        case (cpu_state_q)
            C_IDLE: begin
                if (io.i_cpu_request) begin
                    if (io.i_cpu_rw) begin
                        if (!fifo_full) begin
                            fifo_push   = 1'b1;
                            cpu_state_d = C_ACK;
                        end
                    end else begin
                        cpu_state_d = C_READ;
                    end
                end
            end
            C_ACK:   cpu_state_d = C_IDLE;
            C_READ: begin
                if (read_done) begin
                    cpu_state_d = C_ACK;
                end
            end
            default: cpu_state_d = C_IDLE;
        endcase
        cpu_ready_d = (cpu_state_d == C_ACK);
    end

    // Bus side. Every transaction returns through B_IDLE with the request
    // low, which gives the mandatory idle cycle between bus requests.
    always_comb begin
        bus_state_d = bus_state_q;
        bus_rw_d    = bus_rw_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        fifo_pop    = 1'b0;
        case (bus_state_q)
            B_IDLE: begin
                if (!fifo_empty) begin
                    bus_addr_d  = fifo_head.address;
                    bus_wdata_d = fifo_head.wdata;
                    bus_rw_d    = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_state_d = B_WRITE;
                end else if (cpu_state_q == C_READ) begin
                    bus_addr_d  = io.i_cpu_address;
                    bus_rw_d    = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_state_d = B_READ;
                end
            end
            B_WRITE: begin
                if (io.i_bus_ready) begin
                    fifo_pop    = 1'b1;
                    bus_req_d   = 1'b0;
                    bus_state_d = B_IDLE;
                end
            end
            B_READ: begin
                if (io.i_bus_ready) begin
                    cpu_rdata_d = io.i_bus_rdata;
                    bus_req_d   = 1'b0;
                    bus_state_d = B_IDLE;
                end
            end
            default: bus_state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cpu_state_q <= C_IDLE;
            bus_state_q <= B_IDLE;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            bus_rw_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            cpu_state_q <= cpu_state_d;
            bus_state_q <= bus_state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_rw_q    <= bus_rw_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign io.o_cpu_ready   = cpu_ready_q;
    assign io.o_cpu_rdata   = cpu_rdata_q;
    assign io.o_bus_rw      = bus_rw_q;
    assign io.o_bus_request = bus_req_q;
    assign io.o_bus_address = bus_addr_q;
    assign io.o_bus_wdata   = bus_wdata_q;
    assign io.o_pending     = (fifo_count != '0) || (bus_state_q != B_IDLE);

endmodule
